blackbox_sweeper: RTL and testbench
===================================

# blackbox_sweeper

Sequencer that exercises a 3-input, 1-output combinational gate network (the Lab 1 `blackbox` style: inputs `l`, `s`, `q`, output `m`) through all 8 input combinations. It samples the output after a programmable settle time and assembles an 8-bit truth table. It then compares that table against an expected value and reports the first failing combination. It sits between a test/control host (start/done handshake) and one instance of the network under characterisation.

## Interface

Parameters:
- `SETTLE` (default 1): cycles each combination is held before sampling; legal range 1..15.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a sweep; honoured only in IDLE.
- `abort`  in  1  cancel an in-progress sweep.
- `expected`  in  8  golden truth table; bit i = expected `m` for combination i. Captured at start.
- `bb_m`  in  1  network output.
- `bb_l`, `bb_s`, `bb_q`  out  1 each  network inputs. Combination index i = {l,s,q}, with `l` as MSB.
- `busy`  out  1  high in DRIVE and SAMPLE.
- `done`  out  1  one-cycle pulse when a sweep completes (not on abort).
- `table`  out  8  captured truth table.
- `match`  out  1  `table == expected_q`; valid when `done`, then held.
- `first_bad`  out  3  lowest index i with `table[i] != expected_q[i]`; 0 when `match`.

## Operation

States:
- IDLE: inputs driven to 0.
  - `start` captures `expected` into `expected_q`, clears `table`, sets idx=0 and cnt=0.
  - Next state: DRIVE.
- DRIVE: `{bb_l,bb_s,bb_q}` = idx.
  - cnt increments each cycle.
  - When cnt == SETTLE-1, go to SAMPLE.
- SAMPLE: inputs still = idx.
  - `table[idx] <= bb_m`.
  - If idx == 7, go to DONE.
  - Otherwise idx++, cnt=0, go to DRIVE.
- DONE: computes and latches `match` and `first_bad`, asserts `done` for one cycle, then goes to IDLE.

Rules:
- idx is 3 bits and never wraps within a sweep; the terminal test is idx==7.
- cnt is 4 bits.
- `start` in any state other than IDLE is ignored; no queuing.
- `abort` in DRIVE or SAMPLE goes to IDLE next cycle:
  - no `done`;
  - `table` keeps the partially captured bits;
  - `match`/`first_bad` unchanged from the previous sweep.
- `abort` in IDLE or DONE has no effect. `abort` wins over the SAMPLE capture in the same cycle.
- Simultaneous `start` and `abort` in IDLE: start is honoured.
- `reset` from any state, including mid-sweep:
  - state=IDLE, idx=0, cnt=0;
  - `table`=0, `expected_q`=0;
  - `match`=0, `first_bad`=0, `busy`=0, `done`=0;
  - bb_* = 0.
  - `reset` overrides `start` and `abort`.

## Timing

- All outputs are registered, or decoded from state/idx only; there is no combinational path from `bb_m` to any output.
- `busy` rises the cycle after the edge that samples `start`.
- Each combination takes SETTLE+1 cycles: SETTLE in DRIVE plus 1 in SAMPLE.
- `done` is high exactly 8·(SETTLE+1) cycles after the `start`-sampling edge (16 cycles for SETTLE=1). `busy` is low in that cycle.
- A new `start` is accepted one cycle after `done`, i.e. the cycle IDLE is re-entered.
- The sampled `bb_m` is the value present at the SAMPLE edge. The network therefore has SETTLE+1 cycles of stable inputs before the sample.

## Structure

- Shared package `blackbox_pkg` holds:
  - the state encoding (IDLE, DRIVE, SAMPLE, DONE as 2-bit constants);
  - `IDX_W`=3 and `NUM_COMBOS`=8;
  - `CNT_W`=4.
- One sub-module is natural: `first_mismatch`, a combinational 8-bit priority encoder over `table ^ expected_q` giving `first_bad`.
- The network itself is instantiated outside this block. The bench connects `blackbox` to the bb_* ports.

## Test plan

- Real network, SETTLE=1, `expected`=8'h7F, pulse `start` -> bb_* steps through idx 0..7, two cycles each. `done` at cycle 16, `table`=8'h7F, `match`=1, `first_bad`=0.
- Same network, `expected`=8'hFF -> `table`=8'h7F, `match`=0, `first_bad`=7.
- SETTLE=3, `expected`=8'h7F -> each idx held 4 cycles, `done` at cycle 32, `match`=1.
- Stub network with `bb_m` delayed 2 cycles, SETTLE=1 vs SETTLE=3 -> SETTLE=1 yields a wrong `table` and `match`=0; SETTLE=3 yields `match`=1.
- Pulse `start` again while busy at cycle 5 -> ignored, `done` still at cycle 16. Assert `abort` during SAMPLE of idx 3 -> IDLE next cycle, no `done`, `table[3]` not written.
- Assert `reset` during DRIVE of idx 5 -> next cycle all outputs 0 and state IDLE. A subsequent `start` completes a full sweep normally.

Source files
------------

// File: rtl/blackbox_pkg.sv
// rtl/blackbox_pkg.sv - shared types and sizes for the blackbox truth-table sweeper
package blackbox_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int IDX_W      = 3;
  localparam int NUM_COMBOS = 8;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/blackbox_sweeper_if.sv
// rtl/blackbox_sweeper_if.sv - host start/done handshake and result bundle for the sweeper
interface blackbox_sweeper_if;
  import blackbox_pkg::*;

  logic                  start;
  logic                  abort;
  logic [NUM_COMBOS-1:0] expected;
  logic                  busy;
  logic                  done;
  logic [NUM_COMBOS-1:0] truth_table;
  logic                  match;
  logic [IDX_W-1:0]      first_bad;

  modport master (
    output start, abort, expected,
    input  busy, done, truth_table, match, first_bad
  );

  modport slave (
    input  start, abort, expected,
    output busy, done, truth_table, match, first_bad
  );

endinterface

// File: rtl/blackbox_sweeper_first_mismatch.sv
// rtl/blackbox_sweeper_first_mismatch.sv - priority encoder for lowest differing truth-table bit
module first_mismatch
  import blackbox_pkg::*;
(
  input  logic [NUM_COMBOS-1:0] table_i,
  input  logic [NUM_COMBOS-1:0] expected_i,
  output logic [IDX_W-1:0]      first_bad_o,
  output logic                  match_o
);

  logic [NUM_COMBOS-1:0] diff;

  always_comb begin
    diff        = table_i ^ expected_i;
    first_bad_o = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = NUM_COMBOS - 1; i >= 0; i--) begin
      if (diff[i]) first_bad_o = IDX_W'(i);
    end
    match_o = ~|diff;
  end

endmodule

// File: rtl/blackbox_sweeper.sv
// rtl/blackbox_sweeper.sv - steps a 3-input gate network through all combinations and
// checks the captured truth table against a golden value
module blackbox_sweeper
  import blackbox_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic                clk,
  input  logic                reset,
  blackbox_sweeper_if.slave   host,
  input  logic                bb_m,
  output logic                bb_l,
  output logic                bb_s,
  output logic                bb_q
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_COMBOS - 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_COMBOS-1:0] table_q, table_d;
  logic [NUM_COMBOS-1:0] expected_q, expected_d;
  logic                  match_q, match_d;
  logic [IDX_W-1:0]      first_bad_q, first_bad_d;

  logic                  cmp_match;
  logic [IDX_W-1:0]      cmp_first_bad;
  logic                  busy;

  first_mismatch u_first_mismatch (
    .table_i     (table_q),
    .expected_i  (expected_q),
    .first_bad_o (cmp_first_bad),
    .match_o     (cmp_match)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      table_q     <= '0;
      expected_q  <= '0;
      match_q     <= 1'b0;
      first_bad_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      table_q     <= table_d;
      expected_q  <= expected_d;
      match_q     <= match_d;
      first_bad_q <= first_bad_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    table_d     = table_q;
    expected_d  = expected_q;
    match_d     = match_q;
    first_bad_d = first_bad_q;

    unique case (state_q)
      ST_IDLE: begin
        if (host.start) begin
          expected_d = host.expected;
          table_d    = '0;
          idx_d      = '0;
          cnt_d      = '0;
          state_d    = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (host.abort) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == SETTLE_LAST) state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        // Abort takes priority, leaving the current bit uncaptured.
        if (host.abort) begin
          state_d = ST_IDLE;
        end else begin
          table_d[idx_q] = bb_m;
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            cnt_d   = '0;
            state_d = ST_DRIVE;
          end
        end
      end
      ST_DONE: begin
        match_d     = cmp_match;
        first_bad_d = cmp_first_bad;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);

  assign {bb_l, bb_s, bb_q} = busy ? idx_q : '0;

  // The comparison is shown live during DONE and held from the latched copy afterwards.
  assign host.busy        = busy;
  assign host.done        = (state_q == ST_DONE);
  assign host.truth_table = table_q;
  assign host.match       = (state_q == ST_DONE) ? cmp_match : match_q;
  assign host.first_bad   = (state_q == ST_DONE) ? cmp_first_bad : first_bad_q;

endmodule

// File: tb/tb_blackbox_sweeper.sv
// tb/tb_blackbox_sweeper.sv - scoreboard bench for blackbox_sweeper with SETTLE=1 and SETTLE=3
module tb_blackbox_sweeper;
  import blackbox_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [7:0]  tbl;
    logic        m;
    logic [2:0]  fb;
    logic [31:0] at;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   done_a = 0, done_b = 0;
  int   exp_done_a = 0, exp_done_b = 0;

  blackbox_sweeper_if ha ();
  blackbox_sweeper_if hb ();

  logic bl_a, bs_a, bq_a, bm_a;
  logic bl_b, bs_b, bq_b, bm_b;
  logic stub_a, stub_b;
  logic d1_a = 1'b1, d2_a = 1'b1, d1_b = 1'b1, d2_b = 1'b1;

  // Network under characterisation is a 3-input NAND; the stub delays it by two cycles.
  always @(posedge clk) begin
    d1_a <= ~(bl_a & bs_a & bq_a);
    d2_a <= d1_a;
    d1_b <= ~(bl_b & bs_b & bq_b);
    d2_b <= d1_b;
  end
  assign bm_a = stub_a ? d2_a : ~(bl_a & bs_a & bq_a);
  assign bm_b = stub_b ? d2_b : ~(bl_b & bs_b & bq_b);

  blackbox_sweeper #(.SETTLE(1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .host  (ha.slave),
    .bb_m  (bm_a),
    .bb_l  (bl_a),
    .bb_s  (bs_a),
    .bb_q  (bq_a)
  );

  blackbox_sweeper #(.SETTLE(3)) dut_b (
    .clk   (clk),
    .reset (reset),
    .host  (hb.slave),
    .bb_m  (bm_b),
    .bb_l  (bl_b),
    .bb_s  (bs_b),
    .bb_q  (bq_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (ha.done === 1'b1) begin
      exp_t e;
      done_a++;
      if (q_a.size() == 0) begin
        check("a_spurious_done", done_a, exp_done_a);
      end else begin
        e = q_a.pop_front();
        check("a_table", ha.truth_table, e.tbl);
        check("a_match", ha.match, e.m);
        check("a_first_bad", ha.first_bad, e.fb);
        check("a_done_cycle", cyc, e.at);
        check("a_busy_at_done", ha.busy, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (hb.done === 1'b1) begin
      exp_t e;
      done_b++;
      if (q_b.size() == 0) begin
        check("b_spurious_done", done_b, exp_done_b);
      end else begin
        e = q_b.pop_front();
        check("b_table", hb.truth_table, e.tbl);
        check("b_match", hb.match, e.m);
        check("b_first_bad", hb.first_bad, e.fb);
        check("b_done_cycle", cyc, e.at);
        check("b_busy_at_done", hb.busy, 0);
      end
    end
  end

  task automatic issue(input bit b, input logic [7:0] exp, input bit with_abort, output int k);
    @(negedge clk);
    if (b) begin
      hb.start = 1'b1; hb.expected = exp;
    end else begin
      ha.start = 1'b1; ha.expected = exp; ha.abort = with_abort;
    end
    k = cyc;
    @(negedge clk);
    ha.start = 1'b0; ha.abort = 1'b0; hb.start = 1'b0;
  endtask

  task automatic expect_sweep(input bit b, input logic [7:0] tbl, input logic m,
                              input logic [2:0] fb, input int at);
    exp_t e;
    e.tbl = tbl; e.m = m; e.fb = fb; e.at = 32'(at);
    if (b) begin q_b.push_back(e); exp_done_b++; end
    else   begin q_a.push_back(e); exp_done_a++; end
  endtask

  task automatic wait_done(input bit b, input int bound);
    int waited = 0;
    while (((b ? done_b : done_a) < (b ? exp_done_b : exp_done_a)) && waited < bound) begin
      @(posedge clk);
      waited++;
    end
    if (b) check("b_done_seen", done_b, exp_done_b);
    else   check("a_done_seen", done_a, exp_done_a);
    @(negedge clk);
  endtask

  task automatic check_a_cleared(input string tag);
    check({tag, "_busy"}, ha.busy, 0);
    check({tag, "_done"}, ha.done, 0);
    check({tag, "_table"}, ha.truth_table, 0);
    check({tag, "_match"}, ha.match, 0);
    check({tag, "_first_bad"}, ha.first_bad, 0);
    check({tag, "_bb"}, {bl_a, bs_a, bq_a}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1;
    ha.start = 1'b0; ha.abort = 1'b0; ha.expected = '0;
    hb.start = 1'b0; hb.abort = 1'b0; hb.expected = '0;
    stub_a = 1'b0; stub_b = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_a_cleared("reset");
    reset = 1'b0;

    // Real network, SETTLE=1: bb_* walks 0..7 two cycles each.
    issue(0, 8'h7F, 0, k);
    expect_sweep(0, 8'h7F, 1'b1, 3'd0, k + 17);
    for (int j = 0; j < 16; j++) begin
      check("t1_bb", {bl_a, bs_a, bq_a}, j >> 1);
      check("t1_busy", ha.busy, 1);
      @(negedge clk);
    end
    wait_done(0, 60);

    // Golden table too strict at index 7; start and abort together in IDLE.
    issue(0, 8'hFF, 1, k);
    expect_sweep(0, 8'h7F, 1'b0, 3'd7, k + 17);
    wait_done(0, 60);

    // SETTLE=3: four cycles per combination.
    issue(1, 8'h7F, 0, k);
    expect_sweep(1, 8'h7F, 1'b1, 3'd0, k + 33);
    repeat (3) @(negedge clk);
    check("t3_bb_hold", {bl_b, bs_b, bq_b}, 0);
    @(negedge clk);
    check("t3_bb_next", {bl_b, bs_b, bq_b}, 1);
    wait_done(1, 100);

    // Two-cycle-late network: SETTLE=1 reads the previous combination.
    stub_a = 1'b1;
    repeat (3) @(negedge clk);
    issue(0, 8'h7F, 0, k);
    expect_sweep(0, 8'hFF, 1'b0, 3'd7, k + 17);
    wait_done(0, 60);
    stub_a = 1'b0;

    stub_b = 1'b1;
    repeat (3) @(negedge clk);
    issue(1, 8'h7F, 0, k);
    expect_sweep(1, 8'h7F, 1'b1, 3'd0, k + 33);
    wait_done(1, 100);
    stub_b = 1'b0;

    // Second start while busy is dropped; expected_q stays 8'hFF.
    issue(0, 8'hFF, 0, k);
    expect_sweep(0, 8'h7F, 1'b0, 3'd7, k + 17);
    repeat (4) @(negedge clk);
    ha.start = 1'b1; ha.expected = 8'h00;
    @(negedge clk);
    ha.start = 1'b0;
    wait_done(0, 60);

    // Abort during SAMPLE of idx 3: bits 0..2 kept, bit 3 untouched.
    issue(0, 8'h00, 0, k);
    repeat (7) @(negedge clk);
    check("t7_in_sample3", {bl_a, bs_a, bq_a}, 3);
    ha.abort = 1'b1;
    @(negedge clk);
    ha.abort = 1'b0;
    check("t7_busy", ha.busy, 0);
    check("t7_table", ha.truth_table, 8'h07);
    check("t7_match_held", ha.match, 0);
    check("t7_first_bad_held", ha.first_bad, 7);
    check("t7_bb", {bl_a, bs_a, bq_a}, 0);
    repeat (40) @(negedge clk);
    check("t7_no_done", done_a, exp_done_a);

    // Reset during DRIVE of idx 5, then a clean sweep.
    issue(0, 8'h7F, 0, k);
    repeat (10) @(negedge clk);
    check("t8_in_drive5", {bl_a, bs_a, bq_a}, 5);
    reset = 1'b1;
    @(negedge clk);
    check_a_cleared("t8_reset");
    reset = 1'b0;
    issue(0, 8'h7F, 0, k);
    expect_sweep(0, 8'h7F, 1'b1, 3'd0, k + 17);
    wait_done(0, 60);

    repeat (5) @(negedge clk);
    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);
    check("a_done_total", done_a, exp_done_a);
    check("b_done_total", done_b, exp_done_b);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
